dcache_replace_ctrl: RTL
========================

DCACHE_REPLACE_CTRL -- requirements
Module: dcache_replace_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, set index width (64 sets).
REQ-002 SHALL have parameter WAY_W, default 3, set way-select width; the dirty vector width is 2**WAY_W (8).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port miss_valid  input  1  miss-victim request valid.
REQ-006 SHALL have port miss_index  input  INDEX_W  set index of the victim.
REQ-007 SHALL have port miss_way  input  WAY_W  victim way.
REQ-008 SHALL have port miss_ready  output  1  request accepted when high with miss_valid.
REQ-009 SHALL have port replace2dirty_array_valid  output  1  dirty-array read enable.
REQ-010 SHALL have port replace2dirty_array_index  output  INDEX_W  dirty-array read index.
REQ-011 SHALL have port replace2dirty_array_ready  output  1  read data consumed; releases the array-side holder.
REQ-012 SHALL have port dirty_array2replace_rdata  input  2**WAY_W  dirty bits of the set, one per way.
REQ-013 SHALL have port wb_valid  output  1  writeback request valid.
REQ-014 SHALL have port wb_index  output  INDEX_W  writeback set index.
REQ-015 SHALL have port wb_way  output  WAY_W  writeback way.
REQ-016 SHALL have port wb_ready  input  1  writeback accepted by the bus side.
REQ-017 SHALL have port done_valid  output  1  one-cycle completion pulse.
REQ-018 SHALL have port done_dirty  output  1  victim was dirty (qualified by done_valid).
REQ-019 SHALL have port wb_count  output  16  saturating count of issued writebacks.

Function
REQ-020 SHALL implement the FSM states IDLE, RD, CHK, WB and DONE.
REQ-021 SHALL keep miss_ready high only in IDLE; a handshake (miss_valid and miss_ready) latches miss_index/miss_way and moves to RD.
REQ-022 SHALL ignore miss_valid in every state other than IDLE; the latched index and way are unaffected.
REQ-023 SHALL hold replace2dirty_array_valid high for exactly one cycle in RD, with replace2dirty_array_index equal to the latched index, then move to CHK.
REQ-024 SHALL sample dirty_array2replace_rdata in CHK (one cycle after the read), assert replace2dirty_array_ready for that cycle only, and register bit [latched way].
REQ-025 SHALL go from CHK to WB if the sampled bit is 1, and to DONE otherwise.
REQ-026 SHALL hold wb_valid high in WB with stable wb_index and wb_way (the latched values) until wb_ready is sampled high; the state then moves to DONE.
REQ-027 SHALL complete WB in one cycle if wb_ready is already high on the first WB cycle.
REQ-028 SHALL drive wb_index and wb_way to 0 whenever wb_valid is low.
REQ-029 SHALL increment wb_count by 1 on each wb_valid and wb_ready handshake and SHALL saturate it at 16'hFFFF with no wrap.
REQ-030 SHALL pulse done_valid for one cycle in DONE, with done_dirty equal to the registered dirty bit, then return to IDLE.
REQ-031 SHALL keep done_dirty at 0 when done_valid is low.
REQ-032 SHALL give a minimum turnaround of 4 cycles (accept -> RD -> CHK -> DONE -> IDLE) for a clean victim, and 5 plus any wb_ready stall cycles for a dirty victim.
REQ-033 SHALL register all outputs, or decode them from registered state only, with no combinational path from any input to any output.

Reset
REQ-034 SHALL, while reset is low, immediately force: state IDLE; miss_ready 1; replace2dirty_array_valid, replace2dirty_array_ready, wb_valid, done_valid and done_dirty all 0; indices, ways and wb_count all 0.
REQ-035 SHALL, on reset asserted mid-operation (any state), abandon the operation without a done pulse and SHALL NOT increment wb_count.
REQ-036 SHALL, on the first clock edge after reset release, accept a request if miss_valid is high.

Verification
REQ-037 SHALL pass this case: clean victim, index 6'h15, way 3, rdata 8'b1111_0111 -> read pulse at index 6'h15, no wb_valid, done_valid with done_dirty=0, 4 cycles after accept.
REQ-038 SHALL pass this case: dirty victim, index 6'h3F, way 7, rdata 8'h80, wb_ready held low 3 cycles -> wb_valid high for 4 cycles with wb_index 6'h3F and wb_way 7, then done_dirty=1, wb_count=1.
REQ-039 SHALL pass this case: miss_valid held high throughout two back-to-back requests -> second accepted only on the cycle after DONE; exactly one read pulse per request.
REQ-040 SHALL pass this case: wb_count preloaded to 16'hFFFE by issuing writebacks, then 3 more dirty writebacks -> wb_count ends at 16'hFFFF.
REQ-041 SHALL pass this case: reset low during WB -> wb_valid drops asynchronously, no done_valid, and wb_count is 0 after release.
REQ-042 SHALL pass this case: wb_ready high on the first WB cycle -> wb_valid high exactly 1 cycle, and done_valid on the following cycle.

Source files
------------

// File: rtl/dcache_replace_ctrl.sv
// Victim-replacement controller: reads the victim set's dirty bits, issues a
// writeback for a dirty victim, then reports completion with a one-cycle pulse.
module dcache_replace_ctrl #(
   parameter int INDEX_W = 6,
   parameter int WAY_W   = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  miss_valid,
   input  logic [INDEX_W-1:0]    miss_index,
   input  logic [WAY_W-1:0]      miss_way,
   output logic                  miss_ready,
   output logic                  replace2dirty_array_valid,
   output logic [INDEX_W-1:0]    replace2dirty_array_index,
   output logic                  replace2dirty_array_ready,
   input  logic [2**WAY_W-1:0]   dirty_array2replace_rdata,
   output logic                  wb_valid,
   output logic [INDEX_W-1:0]    wb_index,
   output logic [WAY_W-1:0]      wb_way,
   input  logic                  wb_ready,
   output logic                  done_valid,
   output logic                  done_dirty,
   output logic [15:0]           wb_count
);

   typedef enum logic [2:0] {IDLE, RD, CHK, WB, DONE} state_t;

   state_t             state;
   logic [INDEX_W-1:0] index_q;
   logic [WAY_W-1:0]   way_q;
   logic               dirty_q;
   logic [15:0]        count_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign replace2dirty_array_index = index_q;
   assign wb_count                  = count_q;

   // Every output is a register set on the transition into the state that owns it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state                     <= IDLE;
         miss_ready                <= 1'b1;
         replace2dirty_array_valid <= 1'b0;
         replace2dirty_array_ready <= 1'b0;
         wb_valid                  <= 1'b0;
         wb_index                  <= '0;
         wb_way                    <= '0;
         done_valid                <= 1'b0;
         done_dirty                <= 1'b0;
         index_q                   <= '0;
         way_q                     <= '0;
         dirty_q                   <= 1'b0;
         count_q                   <= '0;
      end else begin
         replace2dirty_array_valid <= 1'b0;
         replace2dirty_array_ready <= 1'b0;
         done_valid                <= 1'b0;
         done_dirty                <= 1'b0;
         case (state)
            IDLE: begin
               if (miss_valid) begin
                  index_q                   <= miss_index;
                  way_q                     <= miss_way;
                  miss_ready                <= 1'b0;
                  replace2dirty_array_valid <= 1'b1;
                  state                     <= RD;
               end
            end
            RD: begin
               replace2dirty_array_ready <= 1'b1;
               state                     <= CHK;
            end
            CHK: begin
               dirty_q <= dirty_array2replace_rdata[way_q];
               if (dirty_array2replace_rdata[way_q]) begin
                  wb_valid <= 1'b1;
                  wb_index <= index_q;
                  wb_way   <= way_q;
                  state    <= WB;
               end else begin
                  done_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            WB: begin
               if (wb_ready) begin
                  count_q    <= sat_inc(count_q);
                  wb_valid   <= 1'b0;
                  wb_index   <= '0;
                  wb_way     <= '0;
                  done_valid <= 1'b1;
                  done_dirty <= dirty_q;
                  state      <= DONE;
               end
            end
            DONE: begin
               miss_ready <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               miss_ready <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
